cache_ctrl_assoc: RTL and testbench

Parametrised controller for an N-way set-associative, write-back, write-allocate cache. It sits between the CPU memory-stage request (rd/wr) and the banked main memory. It drives the per-way cache banks and the memory port through multi-beat write-back and line-fill sequences. It adds victim selection, configurable line length, configurable memory latency and stall-aware beat sequencing.

---
 rtl/cache_ctrl_assoc.sv | 236 +++++++++++++++++++++++
 tb/tb_cache_ctrl_assoc.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: controller for an N-way set-associative, write-back,
// write-allocate cache. It sequences victim write-back, line fill and allocate.
// Optional feature macro: CACHE_CTRL_PERF_EN (hit/miss performance counters).
module cache_ctrl_assoc #(
    parameter int unsigned WAYS    = 2,
    parameter int unsigned WORDS   = 4,
    parameter int unsigned MEM_LAT = 2,
    localparam int unsigned WW     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned OW     = $clog2(WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd,
    input  logic            wr,
    input  logic [WAYS-1:0] hit_way,
    input  logic [WAYS-1:0] valid_way,
    input  logic [WAYS-1:0] dirty_way,
    input  logic            cache_err,
    input  logic            mem_stall,
    input  logic            mem_err,
    output logic [WAYS-1:0] cache_en,
    output logic            comp,
    output logic            cache_write,
    output logic            fill_src,
    output logic [OW-1:0]   cache_word,
    output logic            mem_wr,
    output logic            mem_rd,
    output logic [OW-1:0]   mem_word,
    output logic [WW-1:0]   victim,
    output logic            stall,
    output logic            done,
    output logic            cache_hit,
    output logic            err,
    output logic [15:0]     hit_cnt,
    output logic [15:0]     miss_cnt
);

    localparam int unsigned CW        = $clog2(WORDS + MEM_LAT);
    localparam logic [CW-1:0] WB_LAST   = CW'(WORDS - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(WORDS + MEM_LAT - 1);
    localparam logic [CW-1:0] LAT_C     = CW'(MEM_LAT);
    localparam logic [CW-1:0] WORDS_C   = CW'(WORDS);
    localparam logic [WW-1:0] RR_LAST   = WW'(WAYS - 1);

    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_ALLOC, S_DONE, S_ERR} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [WW-1:0]   victim_q, victim_d;
    logic [WW-1:0]   rr_ptr, rr_d;
    logic [WW-1:0]   vsel;
    logic            vsel_found;
    logic            hit_q, hit_d;
    logic            req, any_err, hit;
    logic [WAYS-1:0] hit_vec, victim_oh;

    assign req       = rd ^ wr;
    assign any_err   = cache_err | mem_err;
    assign hit_vec   = hit_way & valid_way;
    assign hit       = |hit_vec;
    assign victim_oh = WAYS'(1) << victim_q;

    // Victim choice: lowest invalid way, otherwise the round-robin pointer
    always_comb begin
        vsel       = rr_ptr;
        vsel_found = 1'b0;
        for (int i = 0; i < int'(WAYS); i++) begin
            if (!vsel_found && !valid_way[i]) begin
                vsel       = WW'(i);
                vsel_found = 1'b1;
            end
        end
    end

    // State register plus beat counter, latched victim, rr pointer and hit flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            victim_q <= '0;
            rr_ptr   <= '0;
            hit_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            victim_q <= victim_d;
            rr_ptr   <= rr_d;
            hit_q    <= hit_d;
        end
    end

    // Next-state and sequencing counters
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        victim_d = victim_q;
        rr_d     = rr_ptr;
        hit_d    = hit_q;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (rd && wr) begin
                    state_d = S_ERR;
                end else if (req && any_err) begin
                    state_d = S_ERR;
                end else if (req && hit) begin
                    hit_d   = 1'b1;
                    state_d = S_DONE;
                end else if (req) begin
                    hit_d    = 1'b0;
                    victim_d = vsel;
                    rr_d     = (rr_ptr == RR_LAST) ? '0 : rr_ptr + WW'(1);
                    state_d  = (valid_way[vsel] && dirty_way[vsel]) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (any_err) begin
                    state_d = S_ERR;
                end else if (!mem_stall) begin
                    if (cnt == WB_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            S_FILL: begin
                if (any_err) begin
                    state_d = S_ERR;
                end else if (!mem_stall) begin
                    if (cnt == FILL_LAST) begin
                        cnt_d   = '0;
                        state_d = S_ALLOC;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            S_ALLOC: state_d = any_err ? S_ERR : S_DONE;
            S_DONE:  state_d = any_err ? S_ERR : S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        cache_en    = '0;
        comp        = 1'b0;
        cache_write = 1'b0;
        fill_src    = 1'b0;
        cache_word  = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_word    = '0;
        victim      = '0;
        stall       = 1'b0;
        done        = 1'b0;
        cache_hit   = 1'b0;
        err         = 1'b0;
        if (!rst) begin
            victim = victim_q;
            case (state)
                S_IDLE: begin
                    comp     = 1'b1;
                    cache_en = '1;
                    if (wr && !rd && hit && !any_err) begin
                        cache_write = 1'b1;
                        cache_en    = hit_vec;
                    end
                end
                S_WB: begin
                    stall      = 1'b1;
                    cache_en   = victim_oh;
                    mem_wr     = !mem_stall;
                    mem_word   = OW'(cnt);
                    cache_word = OW'(cnt);
                end
                S_FILL: begin
                    stall    = 1'b1;
                    cache_en = victim_oh;
                    if (cnt < WORDS_C) begin
                        mem_rd   = !mem_stall;
                        mem_word = OW'(cnt);
                    end
                    if (cnt >= LAT_C) begin
                        cache_write = !mem_stall;
                        fill_src    = 1'b1;
                        cache_word  = OW'(cnt - LAT_C);
                    end
                end
                S_ALLOC: begin
                    stall       = 1'b1;
                    comp        = 1'b1;
                    cache_en    = victim_oh;
                    cache_write = wr;
                end
                S_DONE: begin
                    done      = 1'b1;
                    cache_hit = hit_q;
                end
                S_ERR: begin
                    stall = 1'b1;
                    err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss counters, bumped once per completed request
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state == S_DONE) begin
            if (hit_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = rst ? 16'd0 : hit_cnt_q;
    assign miss_cnt = rst ? 16'd0 : miss_cnt_q;
`else
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// tb_cache_ctrl_assoc: randomized scoreboard bench for cache_ctrl_assoc.
// A set-level cache model (valid/dirty/tag per way, round-robin pointer)
// predicts each request's outcome; a monitor checks beats and completions.
module tb_cache_ctrl_assoc;

    localparam int WAYS    = 2;
    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int NSETS   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd, wr;
    logic [WAYS-1:0] hit_way, valid_way, dirty_way;
    logic            cache_err, mem_stall, mem_err;
    logic [WAYS-1:0] cache_en;
    logic            comp, cache_write, fill_src;
    logic [1:0]      cache_word, mem_word;
    logic            mem_wr, mem_rd;
    logic [0:0]      victim;
    logic            stall, done, cache_hit, err;
    logic [15:0]     hit_cnt, miss_cnt;

    cache_ctrl_assoc #(.WAYS(WAYS), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
        .cache_err(cache_err), .mem_stall(mem_stall), .mem_err(mem_err),
        .cache_en(cache_en), .comp(comp), .cache_write(cache_write),
        .fill_src(fill_src), .cache_word(cache_word), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .mem_word(mem_word), .victim(victim), .stall(stall),
        .done(done), .cache_hit(cache_hit), .err(err),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit              is_err;
        bit              hit;
        bit              miss;
        int              cyc;
        int              victim;
        int              n_wb;
        int              cpu_wr;
        logic [WAYS-1:0] cpu_en;
        logic [WAYS-1:0] v_oh;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // reference model of the cache banks seen by the controller
    bit mvalid [NSETS][WAYS];
    bit mdirty [NSETS][WAYS];
    int mtag   [NSETS][WAYS];
    int rr     = 0;
    int mhits  = 0;
    int mmisses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // monitor state
    int              wb_n = 0, rd_n = 0, fl_n = 0, cw_n = 0;
    logic [WAYS-1:0] cw_en = '0;
    logic [WAYS-1:0] cur_oh;
    exp_t            ev;

    task automatic clear_mon();
        wb_n = 0; rd_n = 0; fl_n = 0; cw_n = 0; cw_en = '0;
    endtask

    // Monitor: samples 2ns after the falling edge, away from both edges
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            exp_q.delete();
            clear_mon();
        end else begin
            cur_oh = (exp_q.size() > 0) ? exp_q[0].v_oh : '0;
            if (mem_wr) begin
                chk("wb_mem_word", 64'(mem_word), 64'(wb_n));
                chk("wb_cache_word", 64'(cache_word), 64'(wb_n));
                chk("wb_cache_en", 64'(cache_en), 64'(cur_oh));
                chk("wb_comp", 64'(comp), 64'(0));
                wb_n++;
            end
            if (mem_rd) begin
                chk("fill_mem_word", 64'(mem_word), 64'(rd_n));
                rd_n++;
            end
            if (cache_write && fill_src) begin
                chk("fill_cache_word", 64'(cache_word), 64'(fl_n));
                chk("fill_cache_en", 64'(cache_en), 64'(cur_oh));
                chk("fill_comp", 64'(comp), 64'(0));
                fl_n++;
            end
            if (cache_write && !fill_src) begin
                chk("cpu_write_comp", 64'(comp), 64'(1));
                cw_n++;
                cw_en = cache_en;
            end
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_completion: done=%0d err=%0d with no request outstanding at cycle %0d",
                             done, err, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    chk("completion_cycle", 64'(cyc), 64'(ev.cyc));
                    chk("err_pulse", 64'(err), 64'(ev.is_err));
                    chk("done_pulse", 64'(done), 64'(!ev.is_err));
                    if (!ev.is_err) begin
                        chk("cache_hit", 64'(cache_hit), 64'(ev.hit));
                        chk("done_stall_low", 64'(stall), 64'(0));
                        chk("wb_beats", 64'(wb_n), 64'(ev.n_wb));
                        chk("mem_rd_beats", 64'(rd_n), 64'(ev.miss ? WORDS : 0));
                        chk("fill_writes", 64'(fl_n), 64'(ev.miss ? WORDS : 0));
                        chk("cpu_writes", 64'(cw_n), 64'(ev.cpu_wr));
                        if (ev.miss) chk("victim", 64'(victim), 64'(ev.victim));
                        if (ev.cpu_wr != 0) chk("cpu_write_en", 64'(cw_en), 64'(ev.cpu_en));
                    end else begin
                        chk("err_stall_high", 64'(stall), 64'(1));
                    end
                end
                clear_mon();
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL completion_timeout: nothing by cycle %0d, required at cycle %0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
                clear_mon();
            end
        end
    end

    // One CPU request: op 0=rd 1=wr 2=rd&wr; emode 0=none 1=cache_err at request
    // 2=mem_err mid-miss 3=cache_err mid-miss; jfix>0 pins the error cycle
    task automatic do_txn(input int s, input int tag, input int op, input int emode,
                          input bit use_stall, input int jfix);
        exp_t            e;
        logic [WAYS-1:0] hv, vv, dv;
        bit              st_q[$];
        int              work, jerr, lat, c0, nst, prog;
        bit              is_hit, s1;
        for (int w = 0; w < WAYS; w++) begin
            hv[w] = (mtag[s][w] == tag);
            vv[w] = mvalid[s][w];
            dv[w] = mdirty[s][w];
        end
        is_hit = |(hv & vv);
        e.is_err = 0; e.hit = 0; e.miss = 0; e.cyc = 0; e.victim = 0;
        e.n_wb = 0; e.cpu_wr = 0; e.cpu_en = '0; e.v_oh = '0;
        jerr = 0;
        @(negedge clk);
        c0 = cyc;
        rd = (op != 1);
        wr = (op != 0);
        hit_way = hv; valid_way = vv; dirty_way = dv;
        cache_err = (emode == 1);
        if (op == 2 || emode == 1) begin
            e.is_err = 1;
            e.cyc    = c0 + 1;
        end else if (is_hit) begin
            e.hit    = 1;
            e.cyc    = c0 + 1;
            e.cpu_wr = (op == 1);
            e.cpu_en = hv & vv;
            if (op == 1)
                for (int w = 0; w < WAYS; w++) if (hv[w] && vv[w]) mdirty[s][w] = 1;
            mhits++;
        end else begin
            e.miss   = 1;
            e.victim = rr;
            for (int w = WAYS - 1; w >= 0; w--) if (!vv[w]) e.victim = w;
            rr       = (rr + 1) % WAYS;
            e.n_wb   = (vv[e.victim] && dv[e.victim]) ? WORDS : 0;
            e.cpu_wr = (op == 1);
            e.v_oh   = WAYS'(1) << e.victim;
            e.cpu_en = e.v_oh;
            work     = e.n_wb + WORDS + MEM_LAT;
            if (emode >= 2) begin
                jerr     = (jfix > 0) ? jfix : int'($urandom_range(work + 1, 1));
                e.is_err = 1;
                e.cyc    = c0 + jerr + 1;
            end else begin
                nst  = 0;
                prog = 0;
                while (prog < work) begin
                    s1 = use_stall && (nst < 8) && (($urandom % 4) == 0);
                    st_q.push_back(s1);
                    if (s1) nst++;
                    else prog++;
                end
                e.cyc = c0 + st_q.size() + 2;
                mvalid[s][e.victim] = 1;
                mtag[s][e.victim]   = tag;
                mdirty[s][e.victim] = (op == 1);
                mmisses++;
            end
        end
        exp_q.push_back(e);
        lat = e.cyc - c0;
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            cache_err = (emode == 3 && j == jerr);
            mem_err   = (emode == 2 && j == jerr);
            mem_stall = (j <= st_q.size()) ? st_q[j-1] : 1'b0;
        end
        rd = 0; wr = 0; mem_stall = 0; mem_err = 0; cache_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   c0, op, em;
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mvalid[s][w] = 0; mdirty[s][w] = 0; mtag[s][w] = 0;
            end
        // a hitting write held during reset must not leak to any output
        rst = 1; rd = 0; wr = 1; hit_way = 2'b01; valid_way = 2'b01; dirty_way = '0;
        cache_err = 0; mem_stall = 0; mem_err = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("reset_outputs", {cache_en, comp, cache_write, fill_src, cache_word, mem_wr, mem_rd,
                              mem_word, victim, stall, done, cache_hit, err, hit_cnt, miss_cnt}, 64'(0));
        @(negedge clk);
        rst = 0; wr = 0;
        #2;
        chk("idle_comp", 64'(comp), 64'(1));
        chk("idle_cache_en", 64'(cache_en), 64'(2'b11));
        chk("idle_stall", 64'(stall), 64'(0));

        // set 0: way0 tag 9, way1 tag 5, both clean -> read hit in way 1
        mvalid[0][0] = 1; mtag[0][0] = 9;
        mvalid[0][1] = 1; mtag[0][1] = 5;
        do_txn(0, 5, 0, 0, 0, 0);
        // set 1 empty: write miss fills way 0
        do_txn(1, 3, 1, 0, 0, 0);
        // set 2 both valid and dirty: two read misses with write-back
        mvalid[2][0] = 1; mdirty[2][0] = 1; mtag[2][0] = 1;
        mvalid[2][1] = 1; mdirty[2][1] = 1; mtag[2][1] = 2;
        do_txn(2, 7, 0, 0, 0, 0);
        do_txn(2, 8, 0, 0, 0, 0);
        // write hit on freshly allocated way, then stalled dirty miss
        do_txn(1, 3, 1, 0, 0, 0);
        mdirty[2][1] = 1;
        do_txn(2, 11, 0, 0, 1, 0);
        // mem_err at fill counter 3 of a clean miss
        do_txn(1, 6, 0, 2, 0, 4);
        // rd and wr together
        do_txn(0, 9, 2, 0, 0, 0);

        // reset in the middle of a write-back
        mvalid[3][0] = 1; mdirty[3][0] = 1; mtag[3][0] = 1;
        mvalid[3][1] = 1; mdirty[3][1] = 1; mtag[3][1] = 2;
        @(negedge clk);
        c0 = cyc;
        rd = 1; wr = 0; hit_way = '0; valid_way = 2'b11; dirty_way = 2'b11;
        e.is_err = 0; e.hit = 0; e.miss = 1; e.cyc = c0 + 100; e.victim = rr;
        e.n_wb = WORDS; e.cpu_wr = 0; e.v_oh = WAYS'(1) << rr; e.cpu_en = e.v_oh;
        exp_q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        #2;
        chk("rst_mid_wb_outputs", {cache_en, comp, cache_write, fill_src, cache_word, mem_wr, mem_rd,
                                   mem_word, victim, stall, done, cache_hit, err, hit_cnt, miss_cnt}, 64'(0));
        @(negedge clk);
        rst = 0; rd = 0;
        #2;
        chk("post_rst_no_beats", {mem_wr, mem_rd, stall, done, err}, 64'(0));
        chk("post_rst_comp", 64'(comp), 64'(1));
        chk("post_rst_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("post_rst_miss_cnt", 64'(miss_cnt), 64'(0));
        rr = 0; mhits = 0; mmisses = 0;

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            op = (($urandom % 20) == 0) ? 2 : int'($urandom % 2);
            case ($urandom % 16)
                0:       em = (op != 2) ? 1 : 0;
                1:       em = 2;
                2:       em = 3;
                default: em = 0;
            endcase
            do_txn(int'($urandom % NSETS), int'($urandom % 4), op, em, bit'($urandom % 2), 0);
        end

        @(negedge clk);
        #2;
`ifdef CACHE_CTRL_PERF_EN
        chk("hit_cnt", 64'(hit_cnt), 64'(mhits));
        chk("miss_cnt", 64'(miss_cnt), 64'(mmisses));
`else
        chk("hit_cnt_tied", 64'(hit_cnt), 64'(0));
        chk("miss_cnt_tied", 64'(miss_cnt), 64'(0));
`endif
        chk("outstanding_at_end", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
